// File: rtl/lsa_sys_ctrl.sv
// System controller for the LSA core: loader/core RAM arbitration, core reset sequencing,
// halt detection and the LED/watchdog I/O window. Optional watchdog: LSA_SYS_CTRL_WATCHDOG_EN.
module lsa_sys_ctrl #(
    parameter int unsigned RAM_AW    = 12,
    parameter int unsigned WDOG_BITS = 20
) (
    input  logic              clock_in,
    input  logic              reset_in,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [15:0]       ld_addr,
    input  logic [15:0]       ld_data,
    input  logic              ld_last,
    input  logic              ctrl_run,
    input  logic              ctrl_load,
    output logic              core_reset_n,
    input  logic              core_mem_oe,
    input  logic              core_mem_we,
    input  logic [15:0]       core_mem_add,
    input  logic [15:0]       core_mem_out,
    output logic [15:0]       core_mem_in,
    output logic [RAM_AW-1:0] ram_add,
    output logic [15:0]       ram_wdata,
    output logic              ram_we,
    input  logic [15:0]       ram_rdata,
    output logic [7:0]        led_out,
    output logic [1:0]        state_out,
    output logic [31:0]       run_cycles
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [15:0] IO_BASE   = 16'hFF00;
    localparam logic [15:0] LED_ADDR  = 16'hFF00;
    localparam logic [15:0] WDOG_ADDR = 16'hFF01;
    localparam logic [15:0] HALT_ADDR = 16'hFFFF;

    state_t      state;
    state_t      state_nx;
    logic        core_reset_nx;
    logic [7:0]  led_nx;
    logic [31:0] run_cycles_nx;
    logic        halt_seen;
    logic        halt_seen_nx;

    logic ram_space;
    logic ld_fire;
    logic park;
    logic led_wr;
    logic kick_wr;
    logic wdog_fire;

    assign ram_space = core_mem_add < IO_BASE;
    assign ld_ready  = (state == ST_LOAD);
    assign ld_fire   = ld_valid & ld_ready;
    assign park      = (state == ST_RUN) && (core_mem_add == HALT_ADDR) && !core_mem_oe && !core_mem_we;
    assign led_wr    = (state == ST_RUN) && core_mem_we && (core_mem_add == LED_ADDR);
    assign kick_wr   = (state == ST_RUN) && core_mem_we && (core_mem_add == WDOG_ADDR);
    assign state_out = state;

`ifdef LSA_SYS_CTRL_WATCHDOG_EN
    logic [WDOG_BITS-1:0] wdog;
    logic [WDOG_BITS-1:0] wdog_nx;
    logic                 unused_bits;

    // A kick landing on the terminal count still wins over the reset pulse.
    assign wdog_fire   = (state == ST_RUN) && (wdog == '1) && !kick_wr;
    assign unused_bits = ^ld_addr[15:RAM_AW];

    always_comb begin
        wdog_nx = wdog;
        if (state_nx == ST_LOAD) begin
            wdog_nx = '0;
        end else if (state == ST_RUN) begin
            if (kick_wr || wdog_fire) begin
                wdog_nx = '0;
            end else begin
                wdog_nx = WDOG_BITS'(wdog + 1'b1);
            end
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            wdog <= '0;
        end else begin
            wdog <= wdog_nx;
        end
    end
`else
    logic unused_bits;

    assign wdog_fire   = 1'b0;
    assign unused_bits = ^{ld_addr[15:RAM_AW], kick_wr, 1'(WDOG_BITS)};
`endif

    // RAM port: loader owns it in LOAD, the core otherwise (RAM space only for writes).
    always_comb begin
        ram_add   = core_mem_add[RAM_AW-1:0];
        ram_wdata = core_mem_out;
        ram_we    = core_mem_we && ram_space && (state != ST_LOAD);
        if (state == ST_LOAD) begin
            ram_add   = ld_addr[RAM_AW-1:0];
            ram_wdata = ld_data;
            ram_we    = ld_fire;
        end
    end

    // Read mux toward the core; unmapped I/O reads as zero.
    always_comb begin
        core_mem_in = 16'h0000;
        if (ram_space) begin
            core_mem_in = ram_rdata;
        end else if (core_mem_add == LED_ADDR) begin
            core_mem_in = {8'h00, led_out};
        end
    end

    always_comb begin
        state_nx      = state;
        halt_seen_nx  = 1'b0;
        led_nx        = led_out;
        run_cycles_nx = run_cycles;
        core_reset_nx = (state != ST_LOAD) && !wdog_fire;

        case (state)
            ST_LOAD: begin
                if ((ld_fire && ld_last) || ctrl_run) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (run_cycles != 32'hFFFF_FFFF) begin
                    run_cycles_nx = run_cycles + 32'd1;
                end
                if (wdog_fire) begin
                    run_cycles_nx = 32'd0;
                end
                if (led_wr) begin
                    led_nx = core_mem_out[7:0];
                end
                halt_seen_nx = park;
                if (ctrl_load) begin
                    state_nx = ST_LOAD;
                end else if (park && halt_seen) begin
                    state_nx = ST_HALT;
                end
            end
            ST_HALT: begin
                if (ctrl_load) begin
                    state_nx = ST_LOAD;
                end
            end
            default: begin
                state_nx = ST_LOAD;
            end
        endcase

        if (state_nx == ST_LOAD) begin
            run_cycles_nx = 32'd0;
            halt_seen_nx  = 1'b0;
        end
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state        <= ST_LOAD;
            halt_seen    <= 1'b0;
            led_out      <= 8'h00;
            run_cycles   <= 32'd0;
            core_reset_n <= 1'b0;
        end else begin
            state        <= state_nx;
            halt_seen    <= halt_seen_nx;
            led_out      <= led_nx;
            run_cycles   <= run_cycles_nx;
            core_reset_n <= core_reset_nx;
        end
    end

endmodule
